// File: rtl/cipu_stream.sv
// cipu_stream: check-in processing unit.
// Passenger bytes ('A'..'Z') are queued in a FIFO and drained after '$'; baggage bytes are
// stacked in a LIFO and popped in groups on ';' (count from thing_num), or closed by '$'.
// Optional feature macro: CIPU_FIFO2_EN adds a replay pass that re-emits every stored
// passenger on valid_fifo2 after the first drain completes.
module cipu_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LIFO_DEPTH = 16,
  parameter int unsigned NUM_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] people_thing_in,
  input  logic              people_valid,
  output logic              people_ready,
  input  logic [DATA_W-1:0] thing_in,
  input  logic              thing_valid,
  output logic              thing_ready,
  input  logic [NUM_W-1:0]  thing_num,
  input  logic              ready_fifo,
  input  logic              ready_lifo,
  output logic [DATA_W-1:0] people_thing_out,
  output logic              valid_fifo,
  output logic              valid_fifo2,
  output logic [DATA_W-1:0] thing_out,
  output logic              valid_lifo,
  output logic              done_thing,
  output logic              done_fifo,
  output logic              done_fifo2,
  output logic              done_lifo,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = PW + 1;
  localparam int unsigned LW  = (LIFO_DEPTH > 1) ? $clog2(LIFO_DEPTH) : 1;
  localparam int unsigned LCW = $clog2(LIFO_DEPTH + 1);
  localparam int unsigned MW  = (NUM_W > LCW) ? NUM_W : LCW;

  localparam logic [FCW-1:0] FifoFull = FCW'(FIFO_DEPTH);
  localparam logic [LCW-1:0] LifoFull = LCW'(LIFO_DEPTH);

  localparam logic [7:0] ChA      = 8'h41;
  localparam logic [7:0] ChZ      = 8'h5A;
  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChSemi   = 8'h3B;
  localparam logic [7:0] ChZero   = 8'h30;

`ifdef CIPU_FIFO2_EN
  typedef enum logic [2:0] {PLoad, PDrain, PDone, PReplay, PDone2} pst_e;
`else
  typedef enum logic [2:0] {PLoad, PDrain, PDone} pst_e;
`endif

  typedef enum logic [2:0] {TLoad, TPop, TZero, TPulse, TEnd} tst_e;

  // ---------------------------------------------------------------------------------------
  // Passenger FIFO
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  pst_e              pst_q, pst_d;
  logic [PW-1:0]     frd_q, frd_d, fwr_q, fwr_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic              fpush, fovf;
  logic [7:0]        p_byte;

  assign p_byte = people_thing_in[7:0];

`ifdef CIPU_FIFO2_EN
  // Number of passengers ever stored; defines the replay window ending at the write pointer.
  logic [FCW-1:0] ftot_q;

  // Track total stored passengers for the replay pass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ftot_q <= '0;
    end else if (fpush) begin
      ftot_q <= ftot_q + FCW'(1);
    end
  end
`endif

  // Passenger next-state, pointer updates and outputs.
  always_comb begin
    pst_d        = pst_q;
    frd_d        = frd_q;
    fwr_d        = fwr_q;
    fcnt_d       = fcnt_q;
    fpush        = 1'b0;
    fovf         = 1'b0;
    people_ready = 1'b0;
    valid_fifo   = 1'b0;
    done_fifo    = 1'b0;
`ifdef CIPU_FIFO2_EN
    valid_fifo2  = 1'b0;
    done_fifo2   = 1'b0;
`endif
    unique case (pst_q)
      PLoad: begin
        people_ready = 1'b1;
        if (people_valid) begin
          if (p_byte >= ChA && p_byte <= ChZ) begin
            if (fcnt_q == FifoFull) begin
              fovf = 1'b1;
            end else begin
              fpush  = 1'b1;
              fwr_d  = fwr_q + PW'(1);
              fcnt_d = fcnt_q + FCW'(1);
            end
          end else if (p_byte == ChDollar) begin
            // Empty queue skips straight to done so done_fifo shows on the next cycle.
            pst_d = (fcnt_q == '0) ? PDone : PDrain;
          end
        end
      end
      PDrain: begin
        if (fcnt_q == '0) begin
          pst_d = PDone;
        end else begin
          valid_fifo = 1'b1;
          if (ready_fifo) begin
            frd_d  = frd_q + PW'(1);
            fcnt_d = fcnt_q - FCW'(1);
            if (fcnt_q == FCW'(1)) pst_d = PDone;
          end
        end
      end
      PDone: begin
        done_fifo = 1'b1;
`ifdef CIPU_FIFO2_EN
        // Rewind to the oldest stored entry; storage was never cleared by the drain.
        pst_d  = PReplay;
        frd_d  = fwr_q - ftot_q[PW-1:0];
        fcnt_d = ftot_q;
`endif
      end
`ifdef CIPU_FIFO2_EN
      PReplay: begin
        done_fifo = 1'b1;
        if (fcnt_q == '0) begin
          pst_d = PDone2;
        end else begin
          valid_fifo2 = 1'b1;
          if (ready_fifo) begin
            frd_d  = frd_q + PW'(1);
            fcnt_d = fcnt_q - FCW'(1);
            if (fcnt_q == FCW'(1)) pst_d = PDone2;
          end
        end
      end
      PDone2: begin
        done_fifo  = 1'b1;
        done_fifo2 = 1'b1;
      end
`endif
      default: pst_d = PLoad;
    endcase
  end

`ifndef CIPU_FIFO2_EN
  assign valid_fifo2 = 1'b0;
  assign done_fifo2  = 1'b0;
`endif

  assign people_thing_out = (valid_fifo | valid_fifo2) ? fifo_mem[frd_q] : '0;

  // Passenger state and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pst_q  <= PLoad;
      frd_q  <= '0;
      fwr_q  <= '0;
      fcnt_q <= '0;
    end else begin
      pst_q  <= pst_d;
      frd_q  <= frd_d;
      fwr_q  <= fwr_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Passenger storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (fpush) fifo_mem[fwr_q] <= people_thing_in;
  end

  // ---------------------------------------------------------------------------------------
  // Baggage LIFO
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] lifo_mem [LIFO_DEPTH];
  tst_e              tst_q, tst_d;
  logic [LCW-1:0]    lcnt_q, lcnt_d;
  logic [LCW-1:0]    n_q, n_d;
  logic              lpush, lovf, lunf;
  logic [7:0]        t_byte;
  logic [LW-1:0]     lwr_idx, ltop_idx;

  assign t_byte   = thing_in[7:0];
  assign lwr_idx  = LW'(lcnt_q);
  assign ltop_idx = LW'(lcnt_q - LCW'(1));

  // Baggage next-state, stack updates and outputs.
  always_comb begin
    tst_d       = tst_q;
    lcnt_d      = lcnt_q;
    n_d         = n_q;
    lpush       = 1'b0;
    lovf        = 1'b0;
    lunf        = 1'b0;
    thing_ready = 1'b0;
    thing_out   = '0;
    valid_lifo  = 1'b0;
    done_thing  = 1'b0;
    done_lifo   = 1'b0;
    unique case (tst_q)
      TLoad: begin
        thing_ready = 1'b1;
        if (thing_valid) begin
          if (t_byte == ChSemi) begin
            // Pop count is clipped to the current occupancy.
            if (MW'(thing_num) > MW'(lcnt_q)) begin
              lunf = 1'b1;
              n_d  = lcnt_q;
            end else begin
              n_d = LCW'(thing_num);
            end
            if (thing_num == '0) begin
              tst_d = TZero;
            end else if (n_d != '0) begin
              tst_d = TPop;
            end else begin
              tst_d = TPulse;
            end
          end else if (t_byte == ChDollar) begin
            tst_d = TEnd;
          end else if (lcnt_q == LifoFull) begin
            lovf = 1'b1;
          end else begin
            lpush  = 1'b1;
            lcnt_d = lcnt_q + LCW'(1);
          end
        end
      end
      TPop: begin
        valid_lifo = 1'b1;
        thing_out  = lifo_mem[ltop_idx];
        if (ready_lifo) begin
          lcnt_d = lcnt_q - LCW'(1);
          n_d    = n_q - LCW'(1);
          if (n_q == LCW'(1)) tst_d = TPulse;
        end
      end
      TZero: begin
        valid_lifo = 1'b1;
        thing_out  = DATA_W'(ChZero);
        if (ready_lifo) tst_d = TPulse;
      end
      TPulse: begin
        done_thing = 1'b1;
        tst_d      = TLoad;
      end
      TEnd: begin
        done_lifo = 1'b1;
      end
      default: tst_d = TLoad;
    endcase
  end

  // Baggage state, occupancy and pending-pop registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tst_q  <= TLoad;
      lcnt_q <= '0;
      n_q    <= '0;
    end else begin
      tst_q  <= tst_d;
      lcnt_q <= lcnt_d;
      n_q    <= n_d;
    end
  end

  // Baggage storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (lpush) lifo_mem[lwr_idx] <= thing_in;
  end

  // ---------------------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------------------
  logic ovf_q, unf_q;

  // Errors accumulate from either queue until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | fovf | lovf;
      unf_q <= unf_q | lunf;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_cipu_stream.sv
// Self-checking bench for cipu_stream: randomized passenger/baggage traffic checked against
// queue-based reference models, plus directed boundary scenarios.
module tb_cipu_stream;

  localparam int FD = 16;
  localparam int LD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] people_thing_in = '0;
  logic       people_valid = 1'b0;
  logic       people_ready;
  logic [7:0] thing_in = '0;
  logic       thing_valid = 1'b0;
  logic       thing_ready;
  logic [3:0] thing_num = '0;
  logic       ready_fifo = 1'b0;
  logic       ready_lifo = 1'b0;
  logic [7:0] people_thing_out;
  logic       valid_fifo, valid_fifo2;
  logic [7:0] thing_out;
  logic       valid_lifo, done_thing, done_fifo, done_fifo2, done_lifo, ovf_err, unf_err;

  int checks = 0;
  int failures = 0;

  byte unsigned pq[$];
  byte unsigned lq[$];
  bit exp_ovf;
  bit exp_unf;

  cipu_stream #(
    .DATA_W(8), .FIFO_DEPTH(FD), .LIFO_DEPTH(LD), .NUM_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .people_thing_in(people_thing_in), .people_valid(people_valid),
    .people_ready(people_ready),
    .thing_in(thing_in), .thing_valid(thing_valid), .thing_ready(thing_ready),
    .thing_num(thing_num), .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
    .people_thing_out(people_thing_out), .valid_fifo(valid_fifo), .valid_fifo2(valid_fifo2),
    .thing_out(thing_out), .valid_lifo(valid_lifo), .done_thing(done_thing),
    .done_fifo(done_fifo), .done_fifo2(done_fifo2), .done_lifo(done_lifo),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference models.
  function automatic void model_people(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) begin
      if (pq.size() < FD) pq.push_back(b);
      else exp_ovf = 1'b1;
    end
  endfunction

  function automatic void model_thing(input logic [7:0] b);
    if (lq.size() < LD) lq.push_back(b);
    else exp_ovf = 1'b1;
  endfunction

  function automatic logic [7:0] rand_bag();
    logic [7:0] b;
    do b = 8'($urandom_range(33, 126)); while (b == 8'h3B || b == 8'h24);
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    people_valid = 1'b0; thing_valid = 1'b0; ready_fifo = 1'b0; ready_lifo = 1'b0;
    people_thing_in = '0; thing_in = '0; thing_num = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pq.delete(); lq.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  task automatic send_people(input logic [7:0] b);
    people_thing_in = b; people_valid = 1'b1;
    model_people(b);
    @(negedge clk);
    people_valid = 1'b0;
  endtask

  task automatic send_thing(input logic [7:0] b);
    thing_in = b; thing_valid = 1'b1;
    model_thing(b);
    @(negedge clk);
    thing_valid = 1'b0;
  endtask

  // Drain the passenger queue (first pass or replay) and compare against the model.
  task automatic fifo_drain(input bit stall, input bit second, input string name);
    byte unsigned exp[$];
    byte unsigned e;
    int got = 0;
    int cyc = 0;
    bit v, d, rdy;
    exp = pq;
    d = 1'b0;
    while (cyc < 300) begin
      v = second ? valid_fifo2 : valid_fifo;
      d = second ? done_fifo2 : done_fifo;
      if (d && !v) break;
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        e = (got < exp.size()) ? exp[got] : 8'h00;
        checks++;
        if (got >= exp.size() || people_thing_out !== e) begin
          failures++;
          $display("FAIL %s data[%0d] got=%h exp=%h", name, got, people_thing_out, e);
        end
        if (rdy) got++;
      end
      ready_fifo = rdy;
      @(negedge clk);
      cyc++;
    end
    ready_fifo = 1'b0;
    checks++;
    if (got != exp.size() || !d) begin
      failures++;
      $display("FAIL %s count got=%0d exp=%0d done=%0b", name, got, exp.size(), d);
    end
    if (!stall && !second) begin
      checks++;
      if (cyc != exp.size()) begin
        failures++;
        $display("FAIL %s cycles got=%0d exp=%0d", name, cyc, exp.size());
      end
    end
  endtask

  // Issue ';' with a pop count and check the popped group, pulse timing and unf_err.
  // stall: 0 = always ready, 1 = random ready, 2 = alternating ready.
  task automatic lifo_pop(input int num, input int stall, input string name);
    byte unsigned exp[$];
    int n;
    int got = 0;
    logic rdy;
    if (num == 0) begin
      exp.push_back(8'h30);
    end else begin
      n = (num > lq.size()) ? lq.size() : num;
      if (num > lq.size()) exp_unf = 1'b1;
      repeat (n) exp.push_back(lq.pop_back());
    end
    thing_in = 8'h3B; thing_num = 4'(num); thing_valid = 1'b1;
    @(negedge clk);
    thing_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && got < exp.size(); cyc++) begin
      checks++;
      if (valid_lifo !== 1'b1 || thing_out !== exp[got]) begin
        failures++;
        $display("FAIL %s pop[%0d] valid=%b got=%h exp=%h", name, got, valid_lifo, thing_out,
                 exp[got]);
      end
      if (stall == 1) rdy = 1'($urandom_range(0, 1));
      else if (stall == 2) rdy = (cyc % 2 == 0);
      else rdy = 1'b1;
      ready_lifo = rdy;
      @(negedge clk);
      if (rdy) got++;
    end
    ready_lifo = 1'b0;
    checks++;
    if (done_thing !== 1'b1 || thing_ready !== 1'b0 || valid_lifo !== 1'b0 || got != exp.size())
    begin
      failures++;
      $display("FAIL %s pulse done_thing=%b thing_ready=%b valid=%b got=%0d exp=%0d", name,
               done_thing, thing_ready, valid_lifo, got, exp.size());
    end
    @(negedge clk);
    checks++;
    if (done_thing !== 1'b0 || thing_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s reload done_thing=%b thing_ready=%b exp 0/1", name, done_thing,
               thing_ready);
    end
    checks++;
    if (unf_err !== exp_unf) begin
      failures++;
      $display("FAIL %s unf_err got=%b exp=%b", name, unf_err, exp_unf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    people_thing_in = 8'h41; people_valid = 1'b1; thing_in = 8'h31; thing_valid = 1'b1;
    ready_fifo = 1'b1; ready_lifo = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_fifo, valid_fifo2, valid_lifo, done_thing, done_fifo, done_fifo2, done_lifo,
         ovf_err, unf_err} !== 9'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {valid_fifo, valid_fifo2, valid_lifo,
               done_thing, done_fifo, done_fifo2, done_lifo, ovf_err, unf_err});
    end
    checks++;
    if (people_thing_out !== 8'h00 || thing_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=00/00", people_thing_out, thing_out);
    end
    people_valid = 1'b0; thing_valid = 1'b0; ready_fifo = 1'b0; ready_lifo = 1'b0;
    rst = 1'b1;
    pq.delete(); lq.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
    @(negedge clk);
    checks++;
    if (people_ready !== 1'b1 || thing_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b/%b exp=1/1", people_ready, thing_ready);
    end
    // Nothing was stored during reset: '$' finds the FIFO empty.
    send_people(8'h24);
    checks++;
    if (done_fifo !== 1'b1 || valid_fifo !== 1'b0 || people_ready !== 1'b0) begin
      failures++;
      $display("FAIL empty_drain done=%b valid=%b ready=%b exp 1/0/0", done_fifo, valid_fifo,
               people_ready);
    end
    lifo_pop(3, 0, "empty_pop");
  endtask

  task automatic test_passenger_basic();
    string s = "AB1C";
    do_reset();
    for (int i = 0; i < s.len(); i++) send_people(s[i]);
    send_people(8'h24);
    fifo_drain(1'b0, 1'b0, "basic_fifo");
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_ovf got=%b exp=0", ovf_err);
    end
  endtask

  task automatic test_passenger_random();
    int len;
    int r;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      len = (it == 0) ? 20 : $urandom_range(0, 22);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 3);
        if (r < 2 || it == 0) b = 8'($urandom_range(65, 90));
        else if (r == 2) b = 8'($urandom_range(48, 57));
        else b = 8'($urandom_range(97, 122));
        send_people(b);
      end
      send_people(8'h24);
      fifo_drain(1'b1, 1'b0, "rand_fifo");
`ifdef CIPU_FIFO2_EN
      fifo_drain(1'b1, 1'b1, "rand_replay");
      checks++;
      if (done_fifo !== 1'b1 || done_fifo2 !== 1'b1) begin
        failures++;
        $display("FAIL replay_done got=%b/%b exp=1/1", done_fifo, done_fifo2);
      end
`else
      repeat (3) @(negedge clk);
      checks++;
      if (valid_fifo2 !== 1'b0 || done_fifo2 !== 1'b0 || done_fifo !== 1'b1) begin
        failures++;
        $display("FAIL no_replay v2=%b d2=%b d1=%b exp 0/0/1", valid_fifo2, done_fifo2,
                 done_fifo);
      end
`endif
      checks++;
      if (ovf_err !== exp_ovf) begin
        failures++;
        $display("FAIL rand_fifo_ovf got=%b exp=%b", ovf_err, exp_ovf);
      end
    end
  endtask

  task automatic test_baggage_basic();
    do_reset();
    send_thing(8'h31); send_thing(8'h32); send_thing(8'h33);
    lifo_pop(2, 0, "bag_pop2");
    lifo_pop(1, 0, "bag_pop1");
    send_thing(8'h41); send_thing(8'h42);
    lifo_pop(0, 0, "bag_zero");
    lifo_pop(2, 0, "bag_after_zero");
  endtask

  task automatic test_lifo_limits();
    do_reset();
    for (int i = 0; i < LD; i++) send_thing(rand_bag());
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL lifo_full_noovf got=%b exp=0", ovf_err);
    end
    send_thing(rand_bag());
    checks++;
    if (ovf_err !== exp_ovf) begin
      failures++;
      $display("FAIL lifo_ovf got=%b exp=%b", ovf_err, exp_ovf);
    end
    lifo_pop(15, 1, "lifo_pop15");
    lifo_pop(3, 0, "lifo_short");
    do_reset();
    send_thing(8'h61); send_thing(8'h62);
    lifo_pop(15, 0, "lifo_unf");
  endtask

  task automatic test_stall_order();
    do_reset();
    for (int i = 1; i <= 4; i++) send_thing(8'(8'h30 + i));
    lifo_pop(4, 2, "stall_order");
  endtask

  task automatic test_baggage_random();
    int k;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      k = $urandom_range(0, 7);
      for (int i = 0; i < k; i++) send_thing(rand_bag());
      lifo_pop($urandom_range(0, 15), 1, "rand_lifo");
      checks++;
      if (ovf_err !== exp_ovf) begin
        failures++;
        $display("FAIL rand_lifo_ovf got=%b exp=%b", ovf_err, exp_ovf);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] pb, tb;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pb = 8'($urandom_range(65, 90));
      tb = rand_bag();
      people_thing_in = pb; people_valid = 1'b1; thing_in = tb; thing_valid = 1'b1;
      model_people(pb); model_thing(tb);
      @(negedge clk);
    end
    people_valid = 1'b0; thing_valid = 1'b0;
    send_people(8'h24);
    fifo_drain(1'b0, 1'b0, "simul_fifo");
    lifo_pop(5, 0, "simul_lifo");
  endtask

  task automatic test_end();
    do_reset();
    send_thing(8'h35);
    thing_in = 8'h24; thing_valid = 1'b1;
    @(negedge clk);
    thing_valid = 1'b0;
    checks++;
    if (done_lifo !== 1'b1 || thing_ready !== 1'b0) begin
      failures++;
      $display("FAIL lifo_end got=%b/%b exp=1/0", done_lifo, thing_ready);
    end
    ready_lifo = 1'b1;
    repeat (4) @(negedge clk);
    ready_lifo = 1'b0;
    checks++;
    if (done_lifo !== 1'b1 || thing_ready !== 1'b0 || valid_lifo !== 1'b0) begin
      failures++;
      $display("FAIL lifo_end_hold got=%b/%b/%b exp=1/0/0", done_lifo, thing_ready, valid_lifo);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_people(8'h50); send_people(8'h51);
    send_thing(8'h71); send_thing(8'h72);
    send_people(8'h24);
    thing_in = 8'h3B; thing_num = 4'd2; thing_valid = 1'b1;
    @(negedge clk);
    thing_valid = 1'b0;
    checks++;
    if (valid_fifo !== 1'b1 || valid_lifo !== 1'b1 || people_thing_out !== 8'h50 ||
        thing_out !== 8'h72) begin
      failures++;
      $display("FAIL mid_before got=%b/%b %h/%h exp=1/1 50/72", valid_fifo, valid_lifo,
               people_thing_out, thing_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_fifo !== 1'b0 || valid_lifo !== 1'b0 || people_thing_out !== 8'h00 ||
        thing_out !== 8'h00 || done_fifo !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b %h/%h done=%b exp=0/0 00/00 0", valid_fifo,
               valid_lifo, people_thing_out, thing_out, done_fifo);
    end
    rst = 1'b1;
  endtask

`ifdef CIPU_FIFO2_EN
  task automatic test_replay_reset();
    do_reset();
    send_people(8'h58); send_people(8'h59); send_people(8'h24);
    fifo_drain(1'b0, 1'b0, "rp_first");
    ready_fifo = 1'b0;
    for (int i = 0; i < 10 && valid_fifo2 !== 1'b1; i++) @(negedge clk);
    checks++;
    if (valid_fifo2 !== 1'b1 || people_thing_out !== 8'h58 || done_fifo !== 1'b1 ||
        valid_fifo !== 1'b0) begin
      failures++;
      $display("FAIL rp_head v2=%b data=%h d1=%b v1=%b exp 1/58/1/0", valid_fifo2,
               people_thing_out, done_fifo, valid_fifo);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid_fifo, valid_fifo2, done_fifo, done_fifo2} !== 4'b0 ||
        people_thing_out !== 8'h00) begin
      failures++;
      $display("FAIL rp_reset got=%b data=%h exp=0000/00",
               {valid_fifo, valid_fifo2, done_fifo, done_fifo2}, people_thing_out);
    end
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_passenger_basic();
    test_passenger_random();
    test_baggage_basic();
    test_lifo_limits();
    test_stall_order();
    test_baggage_random();
    test_simultaneous();
    test_end();
    test_reset_mid();
`ifdef CIPU_FIFO2_EN
    test_replay_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cipu_stream.md
# cipu_stream

Parametrised second-generation check-in processing unit: accepts a passenger byte stream and a baggage byte stream over valid/ready handshakes, queues passengers in a FIFO and baggage in a LIFO, and returns them under downstream backpressure. It extends the fixed 16-entry unit with configurable depths, occupancy-limited pops, sticky error flags and an optional second FIFO replay pass. It sits between the ASCII front-end parser and the gate/loader output interfaces.

## Interface

- DATA_W, 8: byte width; ASCII compares use bits [7:0]; must be >= 8.
- FIFO_DEPTH, 16: passenger FIFO entries; power of two, >= 2.
- LIFO_DEPTH, 16: baggage LIFO entries; >= 2.
- NUM_W, 4: width of thing_num.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- people_thing_in  in  DATA_W  passenger stream byte.
- people_valid  in  1  people_thing_in valid.
- people_ready  out  1  passenger byte accepted when people_valid && people_ready.
- thing_in  in  DATA_W  baggage stream byte.
- thing_valid  in  1  thing_in valid.
- thing_ready  out  1  baggage byte accepted when thing_valid && thing_ready.
- thing_num  in  NUM_W  pop count, sampled with an accepted ';'.
- ready_fifo / ready_lifo  in  1  downstream ready for passenger / baggage output.
- people_thing_out  out  DATA_W  passenger output byte.
- valid_fifo  out  1  first-pass passenger output valid.
- valid_fifo2  out  1  replay-pass passenger output valid.
- thing_out  out  DATA_W  baggage output byte.
- valid_lifo  out  1  baggage output valid.
- done_thing  out  1  one-cycle pulse, pop group complete.
- done_fifo / done_fifo2 / done_lifo  out  1  level, set on completion, held until reset.
- ovf_err / unf_err  out  1  sticky: push into full queue / pop request exceeding LIFO occupancy.

## Operation

- Reset (rst=0 at edge): all outputs 0, data outputs 0, pointers/counts 0, both FSMs to initial state; storage not cleared.
- Passenger FSM: P_LOAD -> P_DRAIN -> P_DONE, plus P_REPLAY -> P_DONE2 with CIPU_FIFO2_EN.
  - P_LOAD: people_ready=1. Accepted 'A'..'Z' pushed; full FIFO drops byte, sets ovf_err. Accepted '$' -> P_DRAIN. Other bytes ignored.
  - P_DRAIN: people_ready=0; head presented with valid_fifo=1; pop on ready_fifo. Empty -> P_DONE, done_fifo=1.
  - Drain is non-destructive to storage: read pointer moves, write pointer and contents kept.
- Baggage FSM: T_LOAD, T_POP, T_ZERO, T_PULSE, T_END.
  - T_LOAD: thing_ready=1. Byte not ';'/'$' pushed; full LIFO drops byte, sets ovf_err.
  - ';': latch n=min(thing_num, count); thing_num > count sets unf_err. thing_num=0 -> T_ZERO; n>0 -> T_POP; else T_PULSE.
  - T_POP: thing_ready=0; top presented on thing_out with valid_lifo=1; pop per transfer; after n transfers -> T_PULSE.
  - T_ZERO: thing_out=0x30 ("0"), valid_lifo=1 until transfer -> T_PULSE.
  - T_PULSE: done_thing=1 one cycle, thing_ready=0 -> T_LOAD.
  - '$' in T_LOAD -> T_END: done_lifo=1, thing_ready=0 forever.
- The two FSMs are independent; simultaneous accepts on both streams are legal.

## Timing

- Accepted byte written at that edge; counts visible next cycle.
- ';' accepted cycle N -> first valid_lifo at N+1. Back-to-back transfers: one item per cycle with ready_lifo held 1.
- valid/data held stable while ready low (no drop, no change).
- Last baggage transfer at cycle M -> done_thing=1 at M+1, thing_ready=1 at M+2.
- Passenger '$' at N -> valid_fifo at N+1 (if non-empty), else done_fifo=1 at N+1.
- Push into full and simultaneous '$' on same byte impossible (one byte per beat).
- Reset mid-operation: all in-flight output aborted; valid deasserted next cycle.
- Pointers wrap modulo depth; full = count==DEPTH, empty = count==0.

## Configuration

- CIPU_FIFO2_EN defined: after P_DONE, FSM enters P_REPLAY, resets read pointer to first stored entry and re-emits all stored passengers in order on people_thing_out with valid_fifo2/ready_fifo; then P_DONE2, done_fifo2=1. done_fifo stays 1.
- Undefined: P_DONE terminal; valid_fifo2 and done_fifo2 tied 0; replay logic absent.

## Test plan

- Passengers "AB1C$", ready_fifo=1 -> outputs A,B,C on consecutive cycles, then done_fifo=1; '1' ignored.
- Baggage "123;" thing_num=2, ready_lifo=1 -> thing_out 3,2, then done_thing pulse; next ";" thing_num=1 -> 1.
- ";" thing_num=0 -> single thing_out=0x30, done_thing pulse; unf_err stays 0.
- Push 17 items into LIFO_DEPTH=16 -> ovf_err=1; ";" thing_num=15 on 2 stored -> 2 pops, unf_err=1.
- ready_lifo toggled 1/0 during 4-item pop -> data stable while stalled, order 4,3,2,1, no loss.
- CIPU_FIFO2_EN, "XY$" -> X,Y with valid_fifo, done_fifo, then X,Y with valid_fifo2, done_fifo2=1; reset mid-replay clears all outputs.
